// File: rtl/alarm_tone_player.sv
// Alarm song sequencer and square-wave tone generator.
// Steps the music ROM address once per note slot, absorbs the ROM's one-cycle
// read latency, and toggles the speaker every half_period cycles inside the
// tone region of each slot. A short silent gap ends every slot.
module alarm_tone_player #(
   parameter int unsigned NOTE_TICKS = 15_000_000,
   parameter int unsigned GAP_TICKS  = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [31:0] note,
   output logic [7:0]  address,
   output logic        speaker,
   output logic        playing,
   output logic        loop_done
);

   localparam int unsigned DurW = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;

   localparam logic [DurW-1:0] DurLast = DurW'(NOTE_TICKS - 1);
   localparam logic [DurW-1:0] ToneEnd = DurW'(NOTE_TICKS - GAP_TICKS);
   localparam logic [DurW-1:0] DurOne  = DurW'(1);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_FETCH   = 3'd1;
   localparam logic [2:0] ST_LOAD    = 3'd2;
   localparam logic [2:0] ST_PLAY    = 3'd3;
   localparam logic [2:0] ST_ADVANCE = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [7:0]      address_q, address_d;
   logic            speaker_q, speaker_d;
   logic            playing_q, playing_d;
   logic            loop_done_q, loop_done_d;
   logic [31:0]     half_period_q, half_period_d;
   logic [DurW-1:0] dur_cnt_q, dur_cnt_d;
   logic [31:0]     hp_cnt_q, hp_cnt_d;

   // Next-state logic; a low enable overrides every state, including ADVANCE.
   always_comb begin
      state_d       = state_q;
      address_d     = address_q;
      speaker_d     = speaker_q;
      half_period_d = half_period_q;
      dur_cnt_d     = dur_cnt_q;
      hp_cnt_d      = hp_cnt_q;
      loop_done_d   = 1'b0;

      if (!enable) begin
         state_d       = ST_IDLE;
         address_d     = 8'd0;
         speaker_d     = 1'b0;
         half_period_d = 32'd0;
         dur_cnt_d     = '0;
         hp_cnt_d      = 32'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               address_d     = 8'd0;
               speaker_d     = 1'b0;
               half_period_d = 32'd0;
               dur_cnt_d     = '0;
               hp_cnt_d      = 32'd0;
               state_d       = ST_FETCH;
            end
            // ROM is registering note for the current address this cycle.
            ST_FETCH: begin
               state_d = ST_LOAD;
            end
            ST_LOAD: begin
               half_period_d = note;
               dur_cnt_d     = '0;
               hp_cnt_d      = 32'd0;
               speaker_d     = 1'b0;
               state_d       = ST_PLAY;
            end
            ST_PLAY: begin
               dur_cnt_d = dur_cnt_q + DurOne;
               if (dur_cnt_q == DurLast) begin
                  state_d = ST_ADVANCE;
               end
               if ((dur_cnt_q < ToneEnd) && (half_period_q != 32'd0)) begin
                  if (hp_cnt_q == half_period_q - 32'd1) begin
                     speaker_d = ~speaker_q;
                     hp_cnt_d  = 32'd0;
                  end else begin
                     hp_cnt_d = hp_cnt_q + 32'd1;
                  end
               end else begin
                  // Gap region or rest: silence and keep the phase counter parked.
                  speaker_d = 1'b0;
                  hp_cnt_d  = 32'd0;
               end
            end
            ST_ADVANCE: begin
               address_d   = address_q + 8'd1;
               loop_done_d = (address_q == 8'hff);
               state_d     = ST_FETCH;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      playing_d = (state_d != ST_IDLE);
   end

   // State and registered outputs, cleared asynchronously by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         address_q     <= 8'd0;
         speaker_q     <= 1'b0;
         playing_q     <= 1'b0;
         loop_done_q   <= 1'b0;
         half_period_q <= 32'd0;
         dur_cnt_q     <= '0;
         hp_cnt_q      <= 32'd0;
      end else begin
         state_q       <= state_d;
         address_q     <= address_d;
         speaker_q     <= speaker_d;
         playing_q     <= playing_d;
         loop_done_q   <= loop_done_d;
         half_period_q <= half_period_d;
         dur_cnt_q     <= dur_cnt_d;
         hp_cnt_q      <= hp_cnt_d;
      end
   end

   assign address   = address_q;
   assign speaker   = speaker_q;
   assign playing   = playing_q;
   assign loop_done = loop_done_q;

endmodule

// File: tb/tb_alarm_tone_player.sv
// Directed bench for alarm_tone_player with a small registered ROM model.
// Edge 0 of each run is the edge that moves the player from IDLE to FETCH.
module tb_alarm_tone_player;

   localparam int unsigned NT = 20;
   localparam int unsigned GT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] note;
   logic [7:0]  address;
   logic        speaker;
   logic        playing;
   logic        loop_done;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int         e;
      logic [7:0] addr;
      logic       spk;
      logic       play;
      logic       ld;
   } vec_t;

   vec_t vecs[$];

   alarm_tone_player #(
      .NOTE_TICKS(NT),
      .GAP_TICKS (GT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .note     (note),
      .address  (address),
      .speaker  (speaker),
      .playing  (playing),
      .loop_done(loop_done)
   );

   always #5 clk = ~clk;

   // Registered ROM model: 3 at address 0, rest at 1, 1 everywhere else.
   always @(posedge clk) begin
      if (address == 8'd0)      note <= 32'd3;
      else if (address == 8'd1) note <= 32'd0;
      else                      note <= 32'd1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input int e, input logic [7:0] a, input logic s, input logic p,
                               input logic l);
      vec_t v;
      v.e = e; v.addr = a; v.spk = s; v.play = p; v.ld = l;
      vecs.push_back(v);
   endfunction

   // Advance edges 0..last (sampling 1 ns after each), checking table rows as they come up.
   task automatic walk(input int last, output int ld_count, output int ld_edge,
                       output int slot1_high);
      ld_count = 0;
      ld_edge = -1;
      slot1_high = 0;
      for (int e = 0; e <= last; e++) begin
         @(posedge clk);
         #1;
         if (loop_done === 1'b1) begin
            ld_count++;
            ld_edge = e;
         end
         if (e >= 23 && e <= 45 && speaker !== 1'b0) slot1_high++;
         foreach (vecs[i]) begin
            if (vecs[i].e == e) begin
               check($sformatf("addr@%0d", e), {24'd0, address}, {24'd0, vecs[i].addr});
               check($sformatf("spk@%0d", e), {31'd0, speaker}, {31'd0, vecs[i].spk});
               check($sformatf("playing@%0d", e), {31'd0, playing}, {31'd0, vecs[i].play});
               check($sformatf("loop_done@%0d", e), {31'd0, loop_done}, {31'd0, vecs[i].ld});
            end
         end
      end
   endtask

   initial begin
      int ld_count, ld_edge, s1h, bad;

      // Slot 0 (half_period 3): FETCH e0, LOAD e1, PLAY from e2, toggles at e5,8,11,14,17.
      add(0, 8'd0, 1'b0, 1'b1, 1'b0);
      add(2, 8'd0, 1'b0, 1'b1, 1'b0);
      add(4, 8'd0, 1'b0, 1'b1, 1'b0);
      add(5, 8'd0, 1'b1, 1'b1, 1'b0);
      add(7, 8'd0, 1'b1, 1'b1, 1'b0);
      add(8, 8'd0, 1'b0, 1'b1, 1'b0);
      add(11, 8'd0, 1'b1, 1'b1, 1'b0);
      add(14, 8'd0, 1'b0, 1'b1, 1'b0);
      add(17, 8'd0, 1'b1, 1'b1, 1'b0);
      add(18, 8'd0, 1'b1, 1'b1, 1'b0);
      add(19, 8'd0, 1'b0, 1'b1, 1'b0);  // gap region silences the tone
      add(22, 8'd0, 1'b0, 1'b1, 1'b0);
      add(23, 8'd1, 1'b0, 1'b1, 1'b0);
      // Slot 1 is a rest but still 23 cycles long.
      add(45, 8'd1, 1'b0, 1'b1, 1'b0);
      add(46, 8'd2, 1'b0, 1'b1, 1'b0);
      // Slot 2 (half_period 1): PLAY from e48, toggles every edge e49..e64.
      add(48, 8'd2, 1'b0, 1'b1, 1'b0);
      add(49, 8'd2, 1'b1, 1'b1, 1'b0);
      add(50, 8'd2, 1'b0, 1'b1, 1'b0);
      add(63, 8'd2, 1'b1, 1'b1, 1'b0);
      add(64, 8'd2, 1'b0, 1'b1, 1'b0);
      add(65, 8'd2, 1'b0, 1'b1, 1'b0);
      add(69, 8'd3, 1'b0, 1'b1, 1'b0);
      // Wrap at 256*23 = 5888 and seamless replay of slot 0.
      add(5887, 8'd255, 1'b0, 1'b1, 1'b0);
      add(5888, 8'd0, 1'b0, 1'b1, 1'b1);
      add(5889, 8'd0, 1'b0, 1'b1, 1'b0);
      add(5893, 8'd0, 1'b1, 1'b1, 1'b0);
      // Slot 5 after the wrap: FETCH e6003, PLAY from e6005, toggling each edge.
      add(6012, 8'd5, 1'b1, 1'b1, 1'b0);
      add(6013, 8'd5, 1'b0, 1'b1, 1'b0);

      // Reset state, before any clock edge.
      #2;
      check("rst_address", {24'd0, address}, 32'd0);
      check("rst_speaker", {31'd0, speaker}, 32'd0);
      check("rst_playing", {31'd0, playing}, 32'd0);
      check("rst_loop_done", {31'd0, loop_done}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (address !== 8'd0 || playing !== 1'b0 || speaker !== 1'b0 || loop_done !== 1'b0)
            bad++;
      end
      check("idle_disabled_bad_cycles", bad, 32'd0);

      // Full song plus a few slots, then drop enable mid-PLAY in slot 5.
      enable = 1'b1;
      walk(6013, ld_count, ld_edge, s1h);
      check("loop_done_count", ld_count, 32'd1);
      check("loop_done_edge", ld_edge, 32'd5888);
      check("slot1_speaker_high", s1h, 32'd0);
      enable = 1'b0;
      @(posedge clk);
      #1;
      check("drop_address", {24'd0, address}, 32'd0);
      check("drop_speaker", {31'd0, speaker}, 32'd0);
      check("drop_playing", {31'd0, playing}, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      check("drop_idle_address", {24'd0, address}, 32'd0);

      // Replay from slot 0, then drop enable while in ADVANCE of slot 255.
      enable = 1'b1;
      walk(5887, ld_count, ld_edge, s1h);
      check("replay_loop_done_count", ld_count, 32'd0);
      enable = 1'b0;
      @(posedge clk);
      #1;
      check("adv_drop_loop_done", {31'd0, loop_done}, 32'd0);
      check("adv_drop_address", {24'd0, address}, 32'd0);
      check("adv_drop_playing", {31'd0, playing}, 32'd0);
      @(posedge clk);
      #1;
      check("adv_drop_loop_done_late", {31'd0, loop_done}, 32'd0);

      // Asynchronous reset while the speaker is high.
      enable = 1'b1;
      walk(5, ld_count, ld_edge, s1h);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_speaker", {31'd0, speaker}, 32'd0);
      check("async_rst_playing", {31'd0, playing}, 32'd0);
      enable = 1'b0;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      enable = 1'b1;
      walk(23, ld_count, ld_edge, s1h);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
